// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave modelling the nRF24L01 register port: returns STATUS on the
// command byte, serves R_REGISTER / W_REGISTER on the first data byte, and
// drops everything else. SCK/CSN/MOSI are oversampled in the clk_10 domain.
module spi_reg_responder #(
  parameter int         NUM_REGS    = 8,
  parameter int         STATUS_ADDR = 7,
  parameter logic [7:0] STATUS_RST  = 8'h0E,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_10,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       wr_stb,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       busy,
  input  logic [4:0] loc_addr,
  output logic [7:0] loc_rdata
);

  typedef enum logic [2:0] {WAIT_DESEL, IDLE, CMD, DATA, IGNORE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic       sck_d, csn_d;
  logic       sck_s, csn_s, mosi_s;
  logic       sck_rise, sck_fall, csn_rise, csn_fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, next_byte;
  logic [7:0] rx_byte, cmd_rdata;
  logic [4:0] cmd_addr;
  logic       is_write, addr_ok, active, byte_done, do_write;
  logic [7:0] regs [NUM_REGS];

  // Synchronisers. CSN resets to "selected" so a reset released mid-transfer
  // cannot fake a deselect and join the transfer halfway.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      csn_sync  <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      csn_d     <= csn_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_rise = csn_s & ~csn_d;
  assign csn_fall = ~csn_s & csn_d;

  assign active    = (state == CMD) || (state == DATA) || (state == IGNORE);
  assign rx_byte   = {rx_shift, mosi_s};
  assign byte_done = active && sck_rise && (bit_cnt == 3'd7);
  assign addr_ok   = int'(cmd_addr) < NUM_REGS;
  assign do_write  = byte_done && (state == DATA) && is_write && addr_ok;
  assign busy      = active;

  // Register read muxes: local port and the command being decoded this cycle.
  always_comb begin
    loc_rdata = 8'h00;
    cmd_rdata = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (loc_addr == 5'(i))     loc_rdata = regs[i];
      if (rx_byte[4:0] == 5'(i)) cmd_rdata = regs[i];
    end
  end

  // State register.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) state <= WAIT_DESEL;
    else        state <= state_next;
  end

  // Next state; a CSN rise overrides any byte completion in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_DESEL: if (csn_s) state_next = IDLE;
      IDLE:       if (csn_fall) state_next = CMD;
      CMD:        if (byte_done)
                    state_next = (rx_byte[7:6] == 2'b00) ? DATA : IGNORE;
      DATA:       if (byte_done) state_next = IGNORE;
      default:    state_next = state;
    endcase
    if (active && csn_rise) state_next = IDLE;
  end

  // Shift datapath, decode, register file and output strobes.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      next_byte <= '0;
      cmd_addr  <= '0;
      is_write  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == STATUS_ADDR) ? STATUS_RST : 8'h00;
    end else begin
      wr_stb    <= 1'b0;
      cmd_valid <= 1'b0;
      if (state == IDLE && csn_fall) begin
        miso_oe  <= 1'b1;
        miso     <= regs[STATUS_ADDR][7];
        tx_shift <= {regs[STATUS_ADDR][6:0], 1'b0};
        bit_cnt  <= '0;
      end
      if (active) begin
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (byte_done && state == CMD) begin
          cmd_valid <= 1'b1;
          cmd_byte  <= rx_byte;
          cmd_addr  <= rx_byte[4:0];
          is_write  <= (rx_byte[7:5] == 3'b001);
          // Read data is frozen here so later writes cannot alter it.
          next_byte <= (rx_byte[7:5] == 3'b000) ? cmd_rdata : 8'h00;
        end
        if (byte_done && state == DATA) next_byte <= 8'h00;
        if (do_write) begin
          wr_stb  <= 1'b1;
          wr_addr <= cmd_addr;
          wr_data <= rx_byte;
          for (int i = 0; i < NUM_REGS; i++)
            if (cmd_addr == 5'(i)) regs[i] <= rx_byte;
        end
        if (sck_fall) begin
          if (bit_cnt == 3'd0) begin
            miso     <= next_byte[7];
            tx_shift <= {next_byte[6:0], 1'b0};
          end else begin
            miso     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        if (csn_rise) begin
          miso_oe <= 1'b0;
          miso    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench: directed vector table, abort / reset corner sequences,
// then random transfers against a byte-level register model.
`timescale 1ns/1ps
module tb_spi_reg_responder;
  localparam int NR = 8;
  localparam int ST = 7;
  localparam int SS = 2;
  localparam int H  = 6;   // SCK half period in clk_10 cycles

  logic clk_10 = 1'b0, rst_n = 1'b0, sck = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, wr_stb, cmd_valid, busy;
  logic [4:0] wr_addr, loc_addr = '0;
  logic [7:0] wr_data, cmd_byte, loc_rdata;

  int n_checks = 0, n_err = 0;
  logic [12:0] wq[$];
  logic [7:0]  cq[$];
  logic [7:0]  mreg [32];

  typedef struct {
    int n;
    logic [2:0][7:0] tx;
    logic [2:0][7:0] em;
    int nwr;
    logic [4:0] wa;
    logic [7:0] wd;
  } vec_t;

  spi_reg_responder #(.NUM_REGS(NR), .STATUS_ADDR(ST), .STATUS_RST(8'h0E), .SYNC_STAGES(SS)) dut (
    .clk_10(clk_10), .rst_n(rst_n), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .busy(busy),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata));

  always #5 clk_10 = ~clk_10;

  always @(negedge clk_10) begin
    if (wr_stb)    wq.push_back({wr_addr, wr_data});
    if (cmd_valid) cq.push_back(cmd_byte);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2,
                              input logic [7:0] m0, m1, m2,
                              input int nwr, input logic [4:0] wa, input logic [7:0] wd);
    vec_t v;
    v.n = n; v.tx[0] = b0; v.tx[1] = b1; v.tx[2] = b2;
    v.em[0] = m0; v.em[1] = m1; v.em[2] = m2;
    v.nwr = nwr; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 8'h00;
    mreg[ST] = 8'h0E;
  endtask

  // Byte-level behaviour: STATUS first, read data second, one write at most.
  task automatic model_xfer(input logic [2:0][7:0] tx, input int n,
                            output logic [2:0][7:0] em, output int nwr,
                            output logic [4:0] wa, output logic [7:0] wd);
    int a;
    em = '0; nwr = 0; wa = '0; wd = '0;
    a = int'(tx[0][4:0]);
    em[0] = mreg[ST];
    if (tx[0][7:5] == 3'b000 && a < NR) em[1] = mreg[a];
    if (tx[0][7:5] == 3'b001 && n >= 2 && a < NR) begin
      mreg[a] = tx[1]; nwr = 1; wa = tx[0][4:0]; wd = tx[1];
    end
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = v[7-i];
      repeat (H) @(negedge clk_10);
      r[7-i] = miso;
      sck = 1'b1;
      repeat (H) @(negedge clk_10);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [2:0][7:0] tx, input int n, output logic [2:0][7:0] rx);
    logic [7:0] r;
    rx = '0;
    wq.delete(); cq.delete();
    csn = 1'b0;
    repeat (8) @(negedge clk_10);
    for (int b = 0; b < n; b++) begin
      spi_bits(tx[b], 8, r);
      rx[b] = r;
    end
    repeat (H) @(negedge clk_10);
    csn = 1'b1;
    repeat (10) @(negedge clk_10);
  endtask

  task automatic check_xfer(input string nm, input int n, input logic [2:0][7:0] tx,
                            input logic [2:0][7:0] rx, input logic [2:0][7:0] em,
                            input int nwr, input logic [4:0] wa, input logic [7:0] wd);
    for (int b = 0; b < n; b++) chk($sformatf("%s miso%0d", nm, b), rx[b], em[b]);
    chk({nm, " cmd_cnt"}, cq.size(), 1);
    if (cq.size() > 0) chk({nm, " cmd_byte"}, cq[0], tx[0]);
    chk({nm, " wr_cnt"}, wq.size(), nwr);
    if (nwr == 1 && wq.size() == 1) chk({nm, " wr"}, wq[0], {wa, wd});
  endtask

  task automatic loc_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
    loc_addr = a;
    @(negedge clk_10);
    chk(nm, loc_rdata, exp);
  endtask

  initial begin
    vec_t vecs[8];
    logic [2:0][7:0] rx, em;
    logic [7:0] r;
    int nwr, n, k;
    logic [4:0] wa;
    logic [7:0] wd;
    logic [2:0][7:0] tx;

    vecs[0] = mk(1, 8'hFF, 8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 0, 5'd0, 8'h00);
    vecs[1] = mk(2, 8'h25, 8'h5A, 8'h00, 8'h0E, 8'h00, 8'h00, 1, 5'd5, 8'h5A);
    vecs[2] = mk(2, 8'h05, 8'hFF, 8'h00, 8'h0E, 8'h5A, 8'h00, 0, 5'd0, 8'h00);
    vecs[3] = mk(3, 8'h23, 8'hAA, 8'hBB, 8'h0E, 8'h00, 8'h00, 1, 5'd3, 8'hAA);
    vecs[4] = mk(3, 8'h03, 8'hFF, 8'hFF, 8'h0E, 8'hAA, 8'h00, 0, 5'd0, 8'h00);
    vecs[5] = mk(2, 8'h3F, 8'h11, 8'h00, 8'h0E, 8'h00, 8'h00, 0, 5'd0, 8'h00);
    vecs[6] = mk(2, 8'h1F, 8'hFF, 8'h00, 8'h0E, 8'h00, 8'h00, 0, 5'd0, 8'h00);
    vecs[7] = mk(2, 8'h50, 8'hFF, 8'h00, 8'h0E, 8'h00, 8'h00, 0, 5'd0, 8'h00);

    model_reset();
    repeat (3) @(negedge clk_10);
    chk("rst miso", miso, 0);       chk("rst miso_oe", miso_oe, 0);
    chk("rst wr_stb", wr_stb, 0);   chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0); chk("rst cmd_valid", cmd_valid, 0);
    chk("rst cmd_byte", cmd_byte, 0); chk("rst busy", busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_10);
    loc_chk("rst status", 5'd7, 8'h0E);

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      xfer(vecs[v].tx, vecs[v].n, rx);
      model_xfer(vecs[v].tx, vecs[v].n, em, nwr, wa, wd);
      check_xfer($sformatf("vec%0d", v), vecs[v].n, vecs[v].tx, rx,
                 vecs[v].em, vecs[v].nwr, vecs[v].wa, vecs[v].wd);
    end
    loc_chk("loc reg5", 5'd5, 8'h5A);
    loc_chk("loc reg3", 5'd3, 8'hAA);
    loc_chk("loc oob", 5'd9, 8'h00);

    // Abort: W_REGISTER 2 with only half a data byte
    wq.delete(); cq.delete();
    csn = 1'b0;
    repeat (8) @(negedge clk_10);
    spi_bits(8'h22, 8, r);
    chk("abort status", r, 8'h0E);
    spi_bits(8'h77, 4, r);
    chk("abort busy", busy, 1);
    repeat (H) @(negedge clk_10);
    csn = 1'b1;
    k = 0;
    while (k < SS + 2 && miso_oe) begin
      @(negedge clk_10);
      k++;
    end
    chk("abort miso_oe", miso_oe, 0);
    repeat (10) @(negedge clk_10);
    chk("abort wr_cnt", wq.size(), 0);
    chk("abort busy_end", busy, 0);
    loc_chk("abort reg2", 5'd2, mreg[2]);

    // Reset pulse mid-byte with CSN held low
    wq.delete(); cq.delete();
    csn = 1'b0;
    repeat (8) @(negedge clk_10);
    spi_bits(8'h25, 3, r);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk_10);
    chk("mrst miso_oe", miso_oe, 0); chk("mrst busy", busy, 0);
    chk("mrst cmd_byte", cmd_byte, 0);
    rst_n = 1'b1;
    spi_bits(8'hA5, 5, r);
    spi_bits(8'h3C, 8, r);
    chk("mrst miso", r, 8'h00);
    chk("mrst oe_hold", miso_oe, 0);
    chk("mrst busy_hold", busy, 0);
    chk("mrst cmd_cnt", cq.size(), 0);
    repeat (H) @(negedge clk_10);
    csn = 1'b1;
    repeat (10) @(negedge clk_10);
    loc_chk("mrst reg5", 5'd5, 8'h00);
    tx = '0; tx[0] = 8'hFF;
    xfer(tx, 1, rx);
    model_xfer(tx, 1, em, nwr, wa, wd);
    check_xfer("post_rst", 1, tx, rx, em, nwr, wa, wd);

    // Random transfers against the model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: tx[0] = {3'b000, 5'($urandom_range(0, 9))};
        1: tx[0] = {3'b001, 5'($urandom_range(0, 9))};
        default: tx[0] = 8'($urandom_range(64, 255));
      endcase
      tx[1] = 8'($urandom); tx[2] = 8'($urandom);
      n = $urandom_range(1, 3);
      xfer(tx, n, rx);
      model_xfer(tx, n, em, nwr, wa, wd);
      check_xfer($sformatf("rnd%0d", t), n, tx, rx, em, nwr, wa, wd);
      k = $urandom_range(0, 12);
      loc_chk($sformatf("rnd%0d loc", t), 5'(k), (k < NR) ? mreg[k] : 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
